// File: rtl/pot_scan_ctrl.sv
// Round-robin scanner for the six EQ pots through the shared A2D; a complete
// set of new settings reaches the band scalers only on an audio sample tick.
module pot_scan_ctrl #(
   parameter int SCAN_GAP = 16,
   parameter int TIMEOUT  = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cnv_cmplt,
   input  logic [11:0] res,
   input  logic        smpl_tick,
   output logic        strt_cnv,
   output logic [2:0]  chnnl,
   output logic [11:0] LP_pot,
   output logic [11:0] B1_pot,
   output logic [11:0] B2_pot,
   output logic [11:0] B3_pot,
   output logic [11:0] HP_pot,
   output logic [11:0] VOL_pot,
   output logic        pots_vld,
   output logic        scan_done,
   output logic        a2d_err
);

   localparam int          NUM_POTS = 6;
   localparam logic [2:0]  LAST_IDX = 3'd5;
   localparam logic [7:0]  GAP_LAST = 8'(SCAN_GAP - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {GAP, CONV, STORE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic [15:0] to_cnt_q, to_cnt_d;
   logic [2:0]  scan_idx_q, next_idx;
   logic [11:0] cap_q;
   logic [11:0] shadow_q [NUM_POTS];
   logic [11:0] pot_q    [NUM_POTS];
   logic        pending_q;
   logic        start, capture, store, timeout, commit;

   // Scan position -> A2D channel: LP, B1, B2, B3, HP, VOL.
   function automatic logic [2:0] chan_of(input logic [2:0] idx);
      case (idx)
         3'd0:    chan_of = 3'd1;
         3'd1:    chan_of = 3'd0;
         3'd2:    chan_of = 3'd4;
         3'd3:    chan_of = 3'd2;
         3'd4:    chan_of = 3'd3;
         default: chan_of = 3'd7;
      endcase
   endfunction

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      to_cnt_d  = to_cnt_q;
      start     = 1'b0;
      capture   = 1'b0;
      store     = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               start     = 1'b1;
               gap_cnt_d = '0;
               to_cnt_d  = '0;
               state_d   = CONV;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         CONV: begin
            // A completion arriving on the timeout cycle still counts.
            if (cnv_cmplt) begin
               capture = 1'b1;
               state_d = STORE;
            end else if (to_cnt_q == TO_LAST) begin
               timeout   = 1'b1;
               gap_cnt_d = '0;
               state_d   = GAP;
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
         end
         STORE: begin
            store     = 1'b1;
            gap_cnt_d = '0;
            state_d   = GAP;
         end
         default: begin
            gap_cnt_d = '0;
            state_d   = GAP;
         end
      endcase
   end

   assign next_idx = (scan_idx_q == LAST_IDX) ? 3'd0 : scan_idx_q + 3'd1;
   assign commit   = smpl_tick & pending_q;

   // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= GAP;
         gap_cnt_q  <= '0;
         to_cnt_q   <= '0;
         scan_idx_q <= '0;
         chnnl      <= 3'd1;
         strt_cnv   <= 1'b0;
         cap_q      <= '0;
         pending_q  <= 1'b0;
         scan_done  <= 1'b0;
         pots_vld   <= 1'b0;
         a2d_err    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         to_cnt_q  <= to_cnt_d;
         strt_cnv  <= start;
         scan_done <= commit;
         if (capture) cap_q    <= res;
         if (timeout) a2d_err  <= 1'b1;
         if (commit)  pots_vld <= 1'b1;
         if (store) begin
            scan_idx_q <= next_idx;
            chnnl      <= chan_of(next_idx);
         end
         // A VOL store coinciding with a commit re-arms pending: those shadows are newer.
         if (store && scan_idx_q == LAST_IDX) pending_q <= 1'b1;
         else if (commit)                     pending_q <= 1'b0;
      end
   end

   // NOTE: the shadow and pot arrays are reset explicitly; the core must read 12'h000 until the first commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_POTS; i++) begin
            shadow_q[i] <= '0;
            pot_q[i]    <= '0;
         end
      end else begin
         if (store) shadow_q[scan_idx_q] <= cap_q;
         if (commit) begin
            for (int i = 0; i < NUM_POTS; i++) pot_q[i] <= shadow_q[i];
         end
      end
   end

   assign LP_pot  = pot_q[0];
   assign B1_pot  = pot_q[1];
   assign B2_pot  = pot_q[2];
   assign B3_pot  = pot_q[3];
   assign HP_pot  = pot_q[4];
   assign VOL_pot = pot_q[5];

endmodule
